// File: rtl/kyber_net_pkg.sv
// kyber_net_pkg
// Shared types and constants for the coefficient-memory crossbars.
//   NUM_BANKS : number of memory banks / butterfly lanes
//   SEL_W     : width of one bank-to-lane select
//   COEF_W    : coefficient width (values mod 3329 fit in 12 bits)
//   sel_vec_t : one select per bank, index = bank number
//   route_t   : inverse mapping for one read beat (per-lane source bank,
//               per-lane hit flag, and a "not a permutation" error bit)
package kyber_net_pkg;

  localparam int NUM_BANKS = 4;
  localparam int SEL_W     = 2;
  localparam int COEF_W    = 12;

  typedef logic [NUM_BANKS-1:0][SEL_W-1:0] sel_vec_t;

  typedef struct packed {
    logic [NUM_BANKS-1:0][SEL_W-1:0] src;
    logic [NUM_BANKS-1:0]            hit;
    logic                            err;
  } route_t;

endpackage

// File: rtl/perm_inverse_4.sv
// perm_inverse_4
// Purely combinational inverse of a 4-entry bank->lane select vector.
// Also used by the controller's conflict checker.
// Ports:
//   sel_a_0..3 : in  - bank j serves lane sel_a_j
//   src_0..3   : out - lowest bank index that serves lane i
//   hit_0..3   : out - lane i has at least one serving bank
//   err        : out - selects are not pairwise distinct
module perm_inverse_4
  import kyber_net_pkg::*;
(
  input  logic [SEL_W-1:0] sel_a_0,
  input  logic [SEL_W-1:0] sel_a_1,
  input  logic [SEL_W-1:0] sel_a_2,
  input  logic [SEL_W-1:0] sel_a_3,
  output logic [SEL_W-1:0] src_0,
  output logic [SEL_W-1:0] src_1,
  output logic [SEL_W-1:0] src_2,
  output logic [SEL_W-1:0] src_3,
  output logic             hit_0,
  output logic             hit_1,
  output logic             hit_2,
  output logic             hit_3,
  output logic             err
);

  sel_vec_t w_sel;
  route_t   w_route;

  assign w_sel = {sel_a_3, sel_a_2, sel_a_1, sel_a_0};

  // Scanning banks from highest to lowest lets the lowest matching bank
  // overwrite any higher one, so a conflicting lane resolves to the lowest
  // bank index. Any equal pair of selects flags the beat as a non-permutation.
  always_comb begin
    w_route = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      for (int j = NUM_BANKS - 1; j >= 0; j--) begin
        if (w_sel[j] == SEL_W'(i)) begin
          w_route.src[i] = SEL_W'(j);
          w_route.hit[i] = 1'b1;
        end
      end
    end
    for (int a = 0; a < NUM_BANKS; a++) begin
      for (int b = a + 1; b < NUM_BANKS; b++) begin
        if (w_sel[a] == w_sel[b]) begin
          w_route.err = 1'b1;
        end
      end
    end
  end

  assign src_0 = w_route.src[0];
  assign src_1 = w_route.src[1];
  assign src_2 = w_route.src[2];
  assign src_3 = w_route.src[3];
  assign hit_0 = w_route.hit[0];
  assign hit_1 = w_route.hit[1];
  assign hit_2 = w_route.hit[2];
  assign hit_3 = w_route.hit[3];
  assign err   = w_route.err;

endmodule

// File: rtl/network_bank_out.sv
// network_bank_out
// Return-path crossbar: routes bank read data q0..q3 back to butterfly
// lanes using the inverse of the select vector captured at read issue.
// The inverse mapping rides a read_lat-deep pipeline so it meets the
// returning bank data; the routed data is registered with a valid flag.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   rd_en               : read issued this cycle
//   sel_a_0..3          : issue-cycle selects, bank j serves lane sel_a_j
//   q0..q3              : bank read data, valid read_lat cycles after rd_en
//   d_out_0..3          : routed data per lane (registered)
//   out_valid           : d_out_* carry a new beat this cycle
//   perm_err            : this beat's selects were not a permutation
module network_bank_out
  import kyber_net_pkg::*;
#(
  parameter int data_width = COEF_W,
  parameter int read_lat   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [SEL_W-1:0]      sel_a_0,
  input  logic [SEL_W-1:0]      sel_a_1,
  input  logic [SEL_W-1:0]      sel_a_2,
  input  logic [SEL_W-1:0]      sel_a_3,
  input  logic [data_width-1:0] q0,
  input  logic [data_width-1:0] q1,
  input  logic [data_width-1:0] q2,
  input  logic [data_width-1:0] q3,
  output logic [data_width-1:0] d_out_0,
  output logic [data_width-1:0] d_out_1,
  output logic [data_width-1:0] d_out_2,
  output logic [data_width-1:0] d_out_3,
  output logic                  out_valid,
  output logic                  perm_err
);

  route_t                w_route;
  logic [data_width-1:0] w_q      [NUM_BANKS];
  logic [data_width-1:0] w_routed [NUM_BANKS];

  logic                  r_vld    [read_lat];
  route_t                r_route  [read_lat];
  logic [data_width-1:0] r_dout   [NUM_BANKS];
  logic                  r_valid;
  logic                  r_perm_err;

  perm_inverse_4 u_inv (
    .sel_a_0 (sel_a_0),
    .sel_a_1 (sel_a_1),
    .sel_a_2 (sel_a_2),
    .sel_a_3 (sel_a_3),
    .src_0   (w_route.src[0]),
    .src_1   (w_route.src[1]),
    .src_2   (w_route.src[2]),
    .src_3   (w_route.src[3]),
    .hit_0   (w_route.hit[0]),
    .hit_1   (w_route.hit[1]),
    .hit_2   (w_route.hit[2]),
    .hit_3   (w_route.hit[3]),
    .err     (w_route.err)
  );

  assign w_q[0] = q0;
  assign w_q[1] = q1;
  assign w_q[2] = q2;
  assign w_q[3] = q3;

  // Issue-side pipeline: each entry carries its own valid bit and routing,
  // so selects may change every cycle without disturbing reads in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < read_lat; k++) begin
        r_vld[k]   <= 1'b0;
        r_route[k] <= '0;
      end
    end else begin
      r_vld[0]   <= rd_en;
      r_route[0] <= w_route;
      for (int k = 1; k < read_lat; k++) begin
        r_vld[k]   <= r_vld[k-1];
        r_route[k] <= r_route[k-1];
      end
    end
  end

  // Lanes without a serving bank read zero rather than stale bank data.
  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      w_routed[i] = '0;
      if (r_route[read_lat-1].hit[i]) begin
        w_routed[i] = w_q[r_route[read_lat-1].src[i]];
      end
    end
  end

  // Output register: data only updates on a valid beat and otherwise holds,
  // while the flags drop to zero on idle cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        r_dout[i] <= '0;
      end
      r_valid    <= 1'b0;
      r_perm_err <= 1'b0;
    end else begin
      if (r_vld[read_lat-1]) begin
        for (int i = 0; i < NUM_BANKS; i++) begin
          r_dout[i] <= w_routed[i];
        end
      end
      r_valid    <= r_vld[read_lat-1];
      r_perm_err <= r_vld[read_lat-1] & r_route[read_lat-1].err;
    end
  end

  assign d_out_0   = r_dout[0];
  assign d_out_1   = r_dout[1];
  assign d_out_2   = r_dout[2];
  assign d_out_3   = r_dout[3];
  assign out_valid = r_valid;
  assign perm_err  = r_perm_err;

endmodule

// File: tb/tb_network_bank_out.sv
// tb_network_bank_out
// Directed bench for network_bank_out. Three instances share the input
// stimulus (read_lat = 1, 2, 3); each scenario checks the instance whose
// latency it targets against hand-computed lane data and flags.
module tb_network_bank_out;

  logic        clk;
  logic        rst_n;
  logic        rd_en;
  logic [1:0]  sel0, sel1, sel2, sel3;
  logic [11:0] q0, q1, q2, q3;

  logic [11:0] a0, a1, a2, a3;
  logic        aValid, aErr;
  logic [11:0] b0, b1, b2, b3;
  logic        bValid, bErr;
  logic [11:0] c0, c1, c2, c3;
  logic        cValid, cErr;

  int checkCount = 0;
  int failCount  = 0;

  network_bank_out #(.data_width(12), .read_lat(1)) dutLat1 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en),
    .sel_a_0(sel0), .sel_a_1(sel1), .sel_a_2(sel2), .sel_a_3(sel3),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .d_out_0(a0), .d_out_1(a1), .d_out_2(a2), .d_out_3(a3),
    .out_valid(aValid), .perm_err(aErr)
  );

  network_bank_out #(.data_width(12), .read_lat(2)) dutLat2 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en),
    .sel_a_0(sel0), .sel_a_1(sel1), .sel_a_2(sel2), .sel_a_3(sel3),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .d_out_0(b0), .d_out_1(b1), .d_out_2(b2), .d_out_3(b3),
    .out_valid(bValid), .perm_err(bErr)
  );

  network_bank_out #(.data_width(12), .read_lat(3)) dutLat3 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en),
    .sel_a_0(sel0), .sel_a_1(sel1), .sel_a_2(sel2), .sel_a_3(sel3),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .d_out_0(c0), .d_out_1(c1), .d_out_2(c2), .d_out_3(c3),
    .out_valid(cValid), .perm_err(cErr)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Lane 0 in the low 12 bits, lane 3 in the high 12 bits.
  function automatic logic [47:0] packLanes(input logic [11:0] l0, input logic [11:0] l1,
                                            input logic [11:0] l2, input logic [11:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Counts one comparison and reports it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change and outputs
  // are sampled here, well away from the edge itself.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [1:0] s0, input logic [1:0] s1,
                               input logic [1:0] s2, input logic [1:0] s3);
    rd_en = en;
    sel0 = s0; sel1 = s1; sel2 = s2; sel3 = s3;
  endtask

  task automatic setQ(input logic [11:0] v0, input logic [11:0] v1,
                      input logic [11:0] v2, input logic [11:0] v3);
    q0 = v0; q1 = v1; q2 = v2; q3 = v3;
  endtask

  // Pipelined-stream tables for the read_lat = 3 instance.
  logic [1:0]  streamSel [4][4];
  logic [11:0] streamQ   [4][4];
  logic [47:0] streamExp [4];

  initial begin
    streamSel[0] = '{2'd0, 2'd1, 2'd2, 2'd3};
    streamSel[1] = '{2'd1, 2'd2, 2'd3, 2'd0};
    streamSel[2] = '{2'd2, 2'd3, 2'd0, 2'd1};
    streamSel[3] = '{2'd3, 2'd1, 2'd0, 2'd2};
    streamQ[0] = '{12'h100, 12'h101, 12'h102, 12'h103};
    streamQ[1] = '{12'h200, 12'h201, 12'h202, 12'h203};
    streamQ[2] = '{12'h300, 12'h301, 12'h302, 12'h303};
    streamQ[3] = '{12'h400, 12'h401, 12'h402, 12'h403};
    streamExp[0] = packLanes(12'h100, 12'h101, 12'h102, 12'h103);
    streamExp[1] = packLanes(12'h203, 12'h200, 12'h201, 12'h202);
    streamExp[2] = packLanes(12'h302, 12'h303, 12'h300, 12'h301);
    streamExp[3] = packLanes(12'h402, 12'h401, 12'h403, 12'h400);
  end

  // Main directed sequence.
  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    setQ(12'h0, 12'h0, 12'h0, 12'h0);
    tick();
    tick();

    checkOutput("reset_d_lat1", 64'(packLanes(a0, a1, a2, a3)), 64'(48'h0));
    checkOutput("reset_valid", 64'({aValid, bValid, cValid}), 64'(3'b000));
    checkOutput("reset_err", 64'({aErr, bErr, cErr}), 64'(3'b000));
    rst_n = 1'b1;
    tick();

    // Identity routing, read_lat = 1.
    applyStimulus(1'b1, 2'd0, 2'd1, 2'd2, 2'd3);
    tick();
    applyStimulus(1'b0, 2'd3, 2'd3, 2'd3, 2'd3);
    setQ(12'h011, 12'h022, 12'h033, 12'h044);
    checkOutput("ident_not_early", 64'(aValid), 64'(1'b0));
    tick();
    checkOutput("ident_d", 64'(packLanes(a0, a1, a2, a3)),
                64'(packLanes(12'h011, 12'h022, 12'h033, 12'h044)));
    checkOutput("ident_flags", 64'({aValid, aErr}), 64'(2'b10));

    // Inverse mapping: bank0->lane2, bank1->lane0, bank2->lane3, bank3->lane1.
    applyStimulus(1'b1, 2'd2, 2'd0, 2'd3, 2'd1);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    setQ(12'hA00, 12'hB00, 12'hC00, 12'hD00);
    tick();
    checkOutput("inverse_d", 64'(packLanes(a0, a1, a2, a3)),
                64'(packLanes(12'hB00, 12'hD00, 12'hA00, 12'hC00)));
    checkOutput("inverse_flags", 64'({aValid, aErr}), 64'(2'b10));

    // Conflict: lane1 from bank0 (lowest), lane2 unserved reads zero.
    applyStimulus(1'b1, 2'd1, 2'd1, 2'd3, 2'd0);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd1, 2'd2, 2'd3);
    setQ(12'd5, 12'd6, 12'd7, 12'd8);
    tick();
    checkOutput("conflict_d", 64'(packLanes(a0, a1, a2, a3)),
                64'(packLanes(12'd8, 12'd5, 12'd0, 12'd7)));
    checkOutput("conflict_flags", 64'({aValid, aErr}), 64'(2'b11));
    setQ(12'hEEE, 12'hEEE, 12'hEEE, 12'hEEE);
    tick();
    checkOutput("conflict_after_hold", 64'(packLanes(a0, a1, a2, a3)),
                64'(packLanes(12'd8, 12'd5, 12'd0, 12'd7)));
    checkOutput("conflict_after_flags", 64'({aValid, aErr}), 64'(2'b00));

    // Idle gap, read_lat = 1: rd_en 1,0,1 -> out_valid 1,0,1.
    applyStimulus(1'b1, 2'd0, 2'd1, 2'd2, 2'd3);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    setQ(12'h001, 12'h002, 12'h003, 12'h004);
    tick();
    applyStimulus(1'b1, 2'd3, 2'd2, 2'd1, 2'd0);
    setQ(12'h999, 12'h999, 12'h999, 12'h999);
    checkOutput("gap_beat0_valid", 64'(aValid), 64'(1'b1));
    checkOutput("gap_beat0_d", 64'(packLanes(a0, a1, a2, a3)),
                64'(packLanes(12'h001, 12'h002, 12'h003, 12'h004)));
    tick();
    applyStimulus(1'b0, 2'd1, 2'd1, 2'd1, 2'd1);
    setQ(12'h010, 12'h020, 12'h030, 12'h040);
    checkOutput("gap_idle_valid", 64'(aValid), 64'(1'b0));
    checkOutput("gap_idle_hold", 64'(packLanes(a0, a1, a2, a3)),
                64'(packLanes(12'h001, 12'h002, 12'h003, 12'h004)));
    tick();
    checkOutput("gap_beat1_valid", 64'(aValid), 64'(1'b1));
    checkOutput("gap_beat1_d", 64'(packLanes(a0, a1, a2, a3)),
                64'(packLanes(12'h040, 12'h030, 12'h020, 12'h010)));
    setQ(12'h0, 12'h0, 12'h0, 12'h0);
    tick();
    tick();
    tick();

    // Pipelined stream, read_lat = 3: four back-to-back reads, selects
    // change every cycle, q for beat k arrives at cycle k+3.
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        applyStimulus(1'b1, streamSel[c][0], streamSel[c][1], streamSel[c][2], streamSel[c][3]);
      end else begin
        applyStimulus(1'b0, 2'(c), 2'(c + 1), 2'(c + 2), 2'(c + 3));
      end
      if (c >= 3 && c < 7) begin
        setQ(streamQ[c-3][0], streamQ[c-3][1], streamQ[c-3][2], streamQ[c-3][3]);
      end else begin
        setQ(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
      end
      tick();
      if (c + 1 >= 4 && c + 1 <= 7) begin
        checkOutput($sformatf("stream_valid_c%0d", c + 1), 64'(cValid), 64'(1'b1));
        checkOutput($sformatf("stream_d_c%0d", c + 1), 64'(packLanes(c0, c1, c2, c3)),
                    64'(streamExp[c-3]));
        checkOutput($sformatf("stream_err_c%0d", c + 1), 64'(cErr), 64'(1'b0));
      end else begin
        checkOutput($sformatf("stream_idle_c%0d", c + 1), 64'(cValid), 64'(1'b0));
      end
    end
    applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    tick();
    tick();

    // Warm-up read on read_lat = 2 so its output register is non-zero.
    applyStimulus(1'b1, 2'd0, 2'd1, 2'd2, 2'd3);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    tick();
    setQ(12'h7AA, 12'h7BB, 12'h7CC, 12'h7DD);
    checkOutput("lat2_not_early", 64'(bValid), 64'(1'b0));
    tick();
    checkOutput("lat2_d", 64'(packLanes(b0, b1, b2, b3)),
                64'(packLanes(12'h7AA, 12'h7BB, 12'h7CC, 12'h7DD)));
    checkOutput("lat2_valid", 64'(bValid), 64'(1'b1));
    tick();

    // Reset mid-flight, read_lat = 2: the read issued at T must vanish.
    applyStimulus(1'b1, 2'd2, 2'd0, 2'd3, 2'd1);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    setQ(12'h555, 12'h666, 12'h777, 12'h888);
    checkOutput("rst_mid_d", 64'(packLanes(b0, b1, b2, b3)), 64'(48'h0));
    checkOutput("rst_mid_err", 64'(bErr), 64'(1'b0));
    for (int t = 2; t <= 5; t++) begin
      checkOutput($sformatf("rst_mid_valid_T%0d", t), 64'(bValid), 64'(1'b0));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
